// File: rtl/sym_err_counter_if.sv
// Symbol error counter control/data bundle; carries bit_errs only when ERR_BIT_COUNT_EN is defined.
interface sym_err_counter_if #(
    parameter int unsigned CNT_W = 21
);
    logic             sym_en;
    logic [1:0]       ref_sym;
    logic [1:0]       rx_sym;
    logic [4:0]       delay;
    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sym_errs;
`ifdef ERR_BIT_COUNT_EN
    logic [CNT_W-1:0] bit_errs;

    modport master (
        output sym_en, ref_sym, rx_sym, delay, start,
        input  busy, done, sym_errs, bit_errs
    );
    modport slave (
        input  sym_en, ref_sym, rx_sym, delay, start,
        output busy, done, sym_errs, bit_errs
    );
`else
    modport master (
        output sym_en, ref_sym, rx_sym, delay, start,
        input  busy, done, sym_errs
    );
    modport slave (
        input  sym_en, ref_sym, rx_sym, delay, start,
        output busy, done, sym_errs
    );
`endif
endinterface

// File: rtl/sym_err_counter.sv
// Symbol error counter: aligns LFSR reference to received symbols and counts mismatches per window.
// Optional Gray-coded bit error counting is enabled by defining ERR_BIT_COUNT_EN.
module sym_err_counter #(
    parameter int unsigned WINDOW_LOG2 = 20,
    parameter int unsigned MAX_DELAY   = 31,
    parameter int unsigned CNT_W       = 21
) (
    input logic              clk,
    input logic              reset,
    sym_err_counter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, FILL, ACCUM, DONE} state_t;

    state_t                 state_q, state_d;
    logic [4:0]             dly_q, dly_d;
    logic [4:0]             fill_q, fill_d;
    logic [WINDOW_LOG2-1:0] win_q, win_d;
    logic [CNT_W-1:0]       sym_cnt_q, sym_cnt_d;
    logic [CNT_W-1:0]       sym_errs_q, sym_errs_d;
    logic [1:0]             dl_q [MAX_DELAY];
    logic [1:0]             aref;
    logic [1:0]             diff;
`ifdef ERR_BIT_COUNT_EN
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]       bit_errs_q, bit_errs_d;
`endif

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // Entry 0 holds the previous strobe's reference, so delay d reads entry d-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < MAX_DELAY; i++) dl_q[i] <= '0;
        end else if (bus.sym_en) begin
            dl_q[0] <= bus.ref_sym;
            for (int unsigned i = 1; i < MAX_DELAY; i++) dl_q[i] <= dl_q[i-1];
        end
    end

    always_comb begin
        aref = bus.ref_sym;
        if (dly_q != 5'd0) aref = dl_q[dly_q - 5'd1];
        diff = bus.rx_sym ^ aref;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            dly_q      <= '0;
            fill_q     <= '0;
            win_q      <= '0;
            sym_cnt_q  <= '0;
            sym_errs_q <= '0;
`ifdef ERR_BIT_COUNT_EN
            bit_cnt_q  <= '0;
            bit_errs_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            fill_q     <= fill_d;
            win_q      <= win_d;
            sym_cnt_q  <= sym_cnt_d;
            sym_errs_q <= sym_errs_d;
`ifdef ERR_BIT_COUNT_EN
            bit_cnt_q  <= bit_cnt_d;
            bit_errs_q <= bit_errs_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        fill_d     = fill_q;
        win_d      = win_q;
        sym_cnt_d  = sym_cnt_q;
        sym_errs_d = sym_errs_q;
`ifdef ERR_BIT_COUNT_EN
        bit_cnt_d  = bit_cnt_q;
        bit_errs_d = bit_errs_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dly_d     = bus.delay;
                    fill_d    = '0;
                    win_d     = '0;
                    sym_cnt_d = '0;
`ifdef ERR_BIT_COUNT_EN
                    bit_cnt_d = '0;
`endif
                    state_d   = FILL;
                end
            end
            FILL: begin
                if (dly_q == 5'd0) begin
                    state_d = ACCUM;
                end else if (bus.sym_en) begin
                    if (fill_q == dly_q - 5'd1) state_d = ACCUM;
                    else                        fill_d  = fill_q + 5'd1;
                end
            end
            ACCUM: begin
                if (bus.sym_en) begin
                    sym_cnt_d = sat_add(sym_cnt_q, {1'b0, |diff});
`ifdef ERR_BIT_COUNT_EN
                    bit_cnt_d = sat_add(bit_cnt_q, {1'b0, diff[0]} + {1'b0, diff[1]});
`endif
                    win_d = win_q + WINDOW_LOG2'(1);
                    if (win_q == '1) state_d = DONE;
                end
            end
            DONE: begin
                sym_errs_d = sym_cnt_q;
`ifdef ERR_BIT_COUNT_EN
                bit_errs_d = bit_cnt_q;
`endif
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.sym_errs = sym_errs_q;
`ifdef ERR_BIT_COUNT_EN
    assign bus.bit_errs = bit_errs_q;
`endif

endmodule
